// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg
// Shared definitions for the ALU result hand-off stage.
//   DATA_W / REG_AW : default datapath and register-address widths
//   entry_t         : one captured ALU result with its write-back/branch metadata
//   state_t         : occupancy of the two-entry skid buffer
package alu_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] rd_addr;
        logic              reg_write;
        logic              branch_taken;
        logic [DATA_W-1:0] pc_target;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/skid_buf.sv
// skid_buf
// Two-entry valid/ready pipeline register with a registered ready. The main
// register drives the outputs; the skid register catches the one entry that
// arrives in the cycle the downstream stalls.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   flush                      : synchronous discard of everything held (wins over accept/pop)
//   in_valid/in_ready/in_data  : upstream side (in_ready is a flop output)
//   out_valid/out_ready/out_data : downstream side, out_data is the head entry
module skid_buf
    import alu_stage_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    state_t       state_reg, state_next;
    logic [W-1:0] main_reg, main_next;
    logic [W-1:0] skid_reg, skid_next;
    logic         ready_reg, ready_next;
    logic         accept, pop;

    assign accept    = in_valid & ready_reg;
    assign pop       = (state_reg != EMPTY) & out_ready;
    assign in_ready  = ready_reg;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_reg;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_next  = in_data;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_next = in_data;
                    end else if (accept) begin
                        skid_next  = in_data;
                        state_next = FULL;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // ready is low here, so only a pop can happen
                    if (pop) begin
                        main_next  = skid_reg;
                        state_next = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
        // Ready is decided from the next state so it can be a plain flop
        ready_next = (state_next != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
            ready_reg <= ready_next;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered hand-off stage after the ALU. Forms an entry from the ALU result
// and instruction metadata (branch-taken from the zero flag, r0 writes dropped)
// and passes it downstream through a two-entry skid buffer.
// Optional statistics: define ALU_RESULT_STAGE_STATS_EN to add accept_cnt_o and
// stall_cnt_o (32-bit, wrapping, cleared only by reset).
// Ports:
//   clk_i, rst_i (async active-low), flush_i
//   in_valid_i / in_ready_o, alu_result_i, alu_zero_i, rd_addr_i, reg_write_i,
//   branch_i, branch_ne_i, pc_target_i           : upstream entry
//   out_valid_o / out_ready_i, result_o, rd_addr_o, reg_write_o,
//   branch_taken_o, pc_target_o                  : head entry
module alu_result_stage
    import alu_stage_pkg::*;
#(
    parameter int DATA_W = alu_stage_pkg::DATA_W,
    parameter int REG_AW = alu_stage_pkg::REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_write_i,
    input  logic              branch_i,
    input  logic              branch_ne_i,
    input  logic [DATA_W-1:0] pc_target_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_write_o,
    output logic              branch_taken_o,
    output logic [DATA_W-1:0] pc_target_o
`ifdef ALU_RESULT_STAGE_STATS_EN
    ,
    output logic [31:0]       accept_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam int PAY_W = 2 * DATA_W + REG_AW + 2;

    logic             taken;
    logic             write_en;
    logic [PAY_W-1:0] in_payload;
    logic [PAY_W-1:0] out_payload;

    // BEQ is taken on zero, BNE on non-zero
    assign taken    = branch_i & (alu_zero_i ^ branch_ne_i);
    // r0 is hard-wired zero, so a write to it is dropped here
    assign write_en = reg_write_i & (rd_addr_i != '0);

    assign in_payload = {alu_result_i, rd_addr_i, write_en, taken, pc_target_i};

    skid_buf #(
        .W(PAY_W)
    ) u_skid (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .flush     (flush_i),
        .in_valid  (in_valid_i),
        .in_ready  (in_ready_o),
        .in_data   (in_payload),
        .out_valid (out_valid_o),
        .out_ready (out_ready_i),
        .out_data  (out_payload)
    );

    assign {result_o, rd_addr_o, reg_write_o, branch_taken_o, pc_target_o} = out_payload;

`ifdef ALU_RESULT_STAGE_STATS_EN
    logic [31:0] accept_cnt_reg;
    logic [31:0] stall_cnt_reg;
    logic        accept_real;

    // An input arriving together with flush is dropped, so it is not counted
    assign accept_real = in_valid_i & in_ready_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            accept_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            if (accept_real) begin
                accept_cnt_reg <= accept_cnt_reg + 32'd1;
            end
            if (out_valid_o && !out_ready_i) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign accept_cnt_o = accept_cnt_reg;
    assign stall_cnt_o  = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage
// Bench for alu_result_stage: directed cases with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_alu_result_stage;
    import alu_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] alu_result_i = '0;
    logic        alu_zero_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic        reg_write_i = 1'b0;
    logic        branch_i = 1'b0;
    logic        branch_ne_i = 1'b0;
    logic [31:0] pc_target_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o;
    logic        branch_taken_o;
    logic [31:0] pc_target_o;
`ifdef ALU_RESULT_STAGE_STATS_EN
    logic [31:0] accept_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    alu_result_stage dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .alu_result_i   (alu_result_i),
        .alu_zero_i     (alu_zero_i),
        .rd_addr_i      (rd_addr_i),
        .reg_write_i    (reg_write_i),
        .branch_i       (branch_i),
        .branch_ne_i    (branch_ne_i),
        .pc_target_i    (pc_target_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .result_o       (result_o),
        .rd_addr_o      (rd_addr_o),
        .reg_write_o    (reg_write_o),
        .branch_taken_o (branch_taken_o),
        .pc_target_o    (pc_target_o)
`ifdef ALU_RESULT_STAGE_STATS_EN
        ,
        .accept_cnt_o   (accept_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Model: entries currently held by the stage, head first (at most two)
    entry_t      q[$];
    logic [31:0] m_acc = '0;
    logic [31:0] m_stall = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic entry_t make_entry();
        entry_t e;
        e.result       = alu_result_i;
        e.rd_addr      = rd_addr_i;
        e.reg_write    = reg_write_i && (rd_addr_i != 5'd0);
        e.branch_taken = branch_i && (branch_ne_i ? !alu_zero_i : alu_zero_i);
        e.pc_target    = pc_target_i;
        return e;
    endfunction

    // One clock edge of the model, evaluated on the inputs the DUT sees
    task automatic model_step();
        bit acc;
        bit pop;
        acc = in_valid_i && (q.size() < 2);
        pop = (q.size() > 0) && out_ready_i;
        if (q.size() > 0 && !out_ready_i) m_stall++;
        if (flush_i) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(make_entry());
                m_acc++;
            end
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("out_valid", out_valid_o, q.size() > 0);
            chk("in_ready", in_ready_o, q.size() < 2);
            if (q.size() > 0) begin
                chk("result", result_o, q[0].result);
                chk("rd_addr", rd_addr_o, q[0].rd_addr);
                chk("reg_write", reg_write_o, q[0].reg_write);
                chk("branch_taken", branch_taken_o, q[0].branch_taken);
                chk("pc_target", pc_target_o, q[0].pc_target);
            end
`ifdef ALU_RESULT_STAGE_STATS_EN
            chk("accept_cnt", accept_cnt_o, m_acc);
            chk("stall_cnt", stall_cnt_o, m_stall);
`endif
        end
    end

    task automatic drive(input bit v, input logic [31:0] res, input bit zero,
                         input logic [4:0] rd, input bit rw, input bit br, input bit ne,
                         input logic [31:0] tgt, input bit ordy, input bit fl);
        in_valid_i   = v;
        alu_result_i = res;
        alu_zero_i   = zero;
        rd_addr_i    = rd;
        reg_write_i  = rw;
        branch_i     = br;
        branch_ne_i  = ne;
        pc_target_i  = tgt;
        out_ready_i  = ordy;
        flush_i      = fl;
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready_o, 1'b1);
        chk({tag, "_out_valid"}, out_valid_o, 1'b0);
        chk({tag, "_result"}, result_o, 32'd0);
        chk({tag, "_rd_addr"}, rd_addr_o, 5'd0);
        chk({tag, "_reg_write"}, reg_write_o, 1'b0);
        chk({tag, "_taken"}, branch_taken_o, 1'b0);
        chk({tag, "_pc_target"}, pc_target_o, 32'd0);
`ifdef ALU_RESULT_STAGE_STATS_EN
        chk({tag, "_accept_cnt"}, accept_cnt_o, 32'd0);
        chk({tag, "_stall_cnt"}, stall_cnt_o, 32'd0);
`endif
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk_i);
        check_reset_outputs("por");
        rst_i = 1'b1;

        // Stream 8 entries with downstream always ready
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + i, 1'b0, 5'(i + 1), 1'b1, 1'b0, 1'b0, 32'h2000 + i, 1'b1, 1'b0);
            cycle();
            chk("stream_valid", out_valid_o, 1'b1);
            chk("stream_result", result_o, 32'h100 + i);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        chk("stream_drained", out_valid_o, 1'b0);
`ifdef ALU_RESULT_STAGE_STATS_EN
        chk("stream_accept_cnt", accept_cnt_o, 32'd8);
        chk("stream_stall_cnt", stall_cnt_o, 32'd0);
`endif

        // A and B with downstream stalled: buffer fills, head stays A
        drive(1'b1, 32'hAAAA_0001, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'hBBBB_0002, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0);
        cycle();
        chk("full_in_ready", in_ready_o, 1'b0);
        chk("full_head_a", result_o, 32'hAAAA_0001);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        chk("pop_head_b", result_o, 32'hBBBB_0002);
        chk("pop_valid_b", out_valid_o, 1'b1);
        cycle();
        chk("pop_empty", out_valid_o, 1'b0);

        // Branch decode and r0 canonicalisation
        drive(1'b1, 32'h0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0);
        cycle();
        chk("beq_zero_taken", branch_taken_o, 1'b1);
        drive(1'b1, 32'h0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 1'b0);
        cycle();
        chk("bne_zero_not_taken", branch_taken_o, 1'b0);
        drive(1'b1, 32'h55, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h48, 1'b1, 1'b0);
        cycle();
        chk("r0_write_dropped", reg_write_o, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle();

        // Flush from FULL with a concurrent input and pop
        drive(1'b1, 32'hC0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h50, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'hC1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h54, 1'b0, 1'b0);
        cycle();
        chk("pre_flush_full", in_ready_o, 1'b0);
        drive(1'b1, 32'hC2, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h58, 1'b1, 1'b1);
        cycle();
        chk("flush_valid", out_valid_o, 1'b0);
        chk("flush_ready", in_ready_o, 1'b1);
`ifdef ALU_RESULT_STAGE_STATS_EN
        chk("flush_accept_cnt", accept_cnt_o, 32'd15);
`endif
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        chk("flush_dropped", out_valid_o, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, $urandom, ($urandom % 2) == 1,
                  (($urandom % 4) == 0) ? 5'd0 : 5'($urandom),
                  ($urandom % 2) == 1, ($urandom % 2) == 1, ($urandom % 2) == 1,
                  $urandom, ($urandom % 3) != 0, ($urandom % 40) == 0);
            cycle();
        end

        // Asynchronous reset while FULL and stalled
        drive(1'b1, 32'hD0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h60, 1'b0, 1'b0);
        cycle();
        cycle();
        cycle();
        chk("pre_reset_full", in_ready_o, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk_i);
        model_step();
        #2;
        rst_i = 1'b0;
        q.delete();
        m_acc   = '0;
        m_stall = '0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk_i);
        rst_i = 1'b1;

        // Traffic resumes after release
        drive(1'b1, 32'hE0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 32'h70, 1'b1, 1'b0);
        cycle();
        chk("post_reset_result", result_o, 32'hE0);
        chk("post_reset_taken", branch_taken_o, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
